// File: rtl/reg_mem_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file.
// Master drives write/read/clear requests; slave returns read data and busy.
interface reg_mem_2r1w_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 5,
  parameter int LANE_W     = 8
);
  localparam int NUM_LANES = DATA_WIDTH / LANE_W;

  logic                  wen;
  logic [ADDR_BITS-1:0]  waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NUM_LANES-1:0]  wbe;
  logic [ADDR_BITS-1:0]  raddr_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [ADDR_BITS-1:0]  raddr_b;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output wen, waddr, wdata, wbe,
    output raddr_a, raddr_b, clr_req,
    input  rdata_a, rdata_b, busy
  );

  modport slave (
    input  wen, waddr, wdata, wbe,
    input  raddr_a, raddr_b, clr_req,
    output rdata_a, rdata_b, busy
  );
endinterface

// File: rtl/reg_mem_2r1w.sv
// 2-read/1-write register file with lane enables, write-first bypass
// and a hardware clear sequencer that zeroes every entry.
module reg_mem_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 5,
  parameter int LANE_W     = 8
) (
  input logic           clk,
  input logic           rst,
  reg_mem_2r1w_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / LANE_W;
  localparam int DEPTH     = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST = '1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic                  clearing;

  assign clearing = (state_q == S_CLEAR);

  // Merge enabled write lanes over the currently stored word
  always_comb begin
    wr_word = mem_q[bus.waddr];
    for (int k = 0; k < NUM_LANES; k++) begin
      if (bus.wbe[k]) begin
        wr_word[k*LANE_W +: LANE_W] = bus.wdata[k*LANE_W +: LANE_W];
      end
    end
  end

  // Clear sequencer next state: sweep every entry once, then idle
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clr_req) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_ptr_q == LAST) begin
          state_d   = S_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
    endcase
  end

  // Sequencer state and sweep pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage: clearing owns the array, otherwise the write port does
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clearing) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (bus.wen) begin
      mem_q[bus.waddr] <= wr_word;
    end
  end

  // Read data next value with write-first forwarding
  always_comb begin
    rdata_a_d = mem_q[bus.raddr_a];
    rdata_b_d = mem_q[bus.raddr_b];
    if (bus.wen && (bus.waddr == bus.raddr_a)) rdata_a_d = wr_word;
    if (bus.wen && (bus.waddr == bus.raddr_b)) rdata_b_d = wr_word;
    if (clearing) begin
      rdata_a_d = '0;
      rdata_b_d = '0;
    end
  end

  // Registered read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // The read registered on the clr_req edge is masked so data stays 0 while busy
  assign bus.rdata_a = clearing ? '0 : rdata_a_q;
  assign bus.rdata_b = clearing ? '0 : rdata_b_q;
  assign bus.busy    = clearing;
endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Self-checking bench for reg_mem_2r1w: vector table plus
// hand sequences for clear, dropped writes and reset mid-clear.
module tb_reg_mem_2r1w;
  logic clk;
  logic rst;

  reg_mem_2r1w_if #(.DATA_WIDTH(16), .ADDR_BITS(5), .LANE_W(8)) bus_if ();

  reg_mem_2r1w #(.DATA_WIDTH(16), .ADDR_BITS(5), .LANE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          chk;
    logic        wen;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  typedef struct {
    bit          chk;
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa,
                       input logic [15:0] wd, input logic [1:0] be,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic clr);
    bus_if.wen     = wen;
    bus_if.waddr   = wa;
    bus_if.wdata   = wd;
    bus_if.wbe     = be;
    bus_if.raddr_a = ra;
    bus_if.raddr_b = rb;
    bus_if.clr_req = clr;
  endtask

  task automatic tick(input bit chk, input string tag,
                      input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    e.chk = chk;
    e.tag = tag;
    e.a   = ea;
    e.b   = eb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.chk) begin
      check({e.tag, "_a"}, 32'(bus_if.rdata_a), 32'(e.a));
      check({e.tag, "_b"}, 32'(bus_if.rdata_b), 32'(e.b));
    end
  endtask

  function automatic void addv(input string tag, input bit chk,
                               input logic wen, input logic [4:0] wa,
                               input logic [15:0] wd, input logic [1:0] be,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic [15:0] ea, input logic [15:0] eb);
    vec_t v;
    v.tag = tag; v.chk = chk; v.wen = wen; v.waddr = wa;
    v.wdata = wd; v.wbe = be; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endfunction

  initial begin
    int cnt;
    int bad;

    for (int i = 0; i < 32; i++)
      addv("wr", 0, 1, 5'(i), 16'(i + 10), 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      addv("rd", 1, 0, 0, 0, 0, 5'(i), 5'(31 - i),
           16'(i + 10), 16'(41 - i));
    addv("t3_w1", 0, 1, 3, 16'h1234, 2'b11, 0, 0, 0, 0);
    addv("t3_lane0", 1, 1, 3, 16'hABCD, 2'b01, 3, 3, 16'h12CD, 16'h12CD);
    addv("t3_lane1", 1, 1, 3, 16'hEE00, 2'b10, 3, 0, 16'hEECD, 16'h000A);
    addv("t3_nowbe", 1, 1, 3, 16'hFFFF, 2'b00, 3, 3, 16'hEECD, 16'hEECD);
    addv("t3_hold", 1, 0, 0, 0, 0, 3, 3, 16'hEECD, 16'hEECD);
    addv("t4_w", 0, 1, 5, 16'h1111, 2'b11, 0, 0, 0, 0);
    addv("t4_byp", 1, 1, 5, 16'h00FF, 2'b11, 5, 6, 16'h00FF, 16'h0010);
    addv("t4_rd", 1, 0, 0, 0, 0, 5, 5, 16'h00FF, 16'h00FF);
    addv("t4_bypb", 1, 1, 7, 16'h0F0F, 2'b01, 6, 7, 16'h0010, 16'h000F);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus_if.busy), 0);
    rst = 1'b0;

    drive(0, 0, 0, 0, 7, 0, 0);
    tick(1, "rst_read", 16'h0000, 16'h0000);
    check("rst_busy2", 32'(bus_if.busy), 0);

    foreach (vecs[n]) begin
      drive(vecs[n].wen, vecs[n].waddr, vecs[n].wdata, vecs[n].wbe,
            vecs[n].ra, vecs[n].rb, 0);
      tick(vecs[n].chk, vecs[n].tag, vecs[n].ea, vecs[n].eb);
    end

    drive(1, 2, 16'h5555, 2'b11, 2, 2, 1);
    tick(0, "clr_go", 0, 0);
    check("busy_rise", 32'(bus_if.busy), 1);
    cnt = 0;
    bad = 0;
    while (bus_if.busy && cnt < 100) begin
      if (bus_if.rdata_a !== 16'h0 || bus_if.rdata_b !== 16'h0) bad++;
      cnt++;
      drive(0, 0, 0, 0, 9, 3, 0);
      if (cnt == 5) drive(1, 9, 16'hAAAA, 2'b11, 9, 9, 0);
      if (cnt == 8) drive(0, 0, 0, 0, 9, 3, 1);
      tick(0, "clr", 0, 0);
    end
    check("clr_len", 32'(cnt), 32);
    check("clr_rdata_zero", 32'(bad), 0);
    check("busy_fall", 32'(bus_if.busy), 0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 0);
      tick(1, "clr_rd", 16'h0000, 16'h0000);
    end

    drive(1, 20, 16'h7777, 2'b11, 20, 0, 0);
    tick(1, "t6_pre", 16'h7777, 16'h0000);
    drive(0, 0, 0, 0, 20, 20, 1);
    tick(0, "t6_go", 0, 0);
    drive(0, 0, 0, 0, 20, 20, 0);
    repeat (9) tick(0, "t6_run", 0, 0);
    check("t6_busy_pre", 32'(bus_if.busy), 1);
    rst = 1'b1;
    #1;
    check("t6_busy_rst", 32'(bus_if.busy), 0);
    check("t6_rdata_rst", {bus_if.rdata_a, bus_if.rdata_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 4, 16'hBEEF, 2'b11, 0, 0, 0);
    tick(0, "t6_w", 0, 0);
    drive(0, 0, 0, 0, 4, 20, 0);
    tick(1, "t6_rd", 16'hBEEF, 16'h0000);
    check("t6_busy_end", 32'(bus_if.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
